busca_instrucao: RTL and testbench

//  nRISC instruction fetch/PC stage, directly upstream of the registered control unit.

---
 rtl/busca_instrucao_pkg.sv | 39 +++
 rtl/busca_instrucao_calc_prox_pc.sv | 57 +++++
 rtl/busca_instrucao.sv | 112 +++++++++++
 tb/tb_busca_instrucao.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busca_instrucao_pkg.sv
// -----------------------------------------------------------------------------
// busca_instrucao_pkg
//   Shared nRISC definitions used by the fetch/PC stage and its next-PC helper:
//   opcode constants, fetch-sequencer state encodings and instruction field
//   geometry.
//
//   Contents
//     OPCODE_W, IMM5_W, STATE_W   field and state widths
//     state_t                     3-bit sequencer state type
//     ST_IDLE .. ST_HALT          sequencer state encodings
//     OP_BNE .. OP_HALT           3-bit opcode constants (instr[MSB -: 3])
// -----------------------------------------------------------------------------
package busca_instrucao_pkg;

  localparam int OPCODE_W = 3;
  localparam int IMM5_W   = 5;
  localparam int STATE_W  = 3;

  typedef logic [STATE_W-1:0] state_t;

  // Sequencer states. Encodings are fixed so that existing tooling that
  // decodes the raw state value keeps working.
  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_FETCH  = 3'b001;
  localparam logic [2:0] ST_DECODE = 3'b010;
  localparam logic [2:0] ST_EXEC   = 3'b011;
  localparam logic [2:0] ST_HALT   = 3'b100;

  // Opcodes, shared with the registered control unit.
  localparam logic [OPCODE_W-1:0] OP_BNE  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_SW   = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_JUMP = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_HALT = 3'b111;

endpackage

// File: rtl/busca_instrucao_calc_prox_pc.sv
// -----------------------------------------------------------------------------
// busca_instrucao_calc_prox_pc
//   Purely combinational next-PC selection for the nRISC fetch stage. Also
//   instantiated stand-alone by the datapath bench, so it carries no state
//   and knows nothing about halting (the caller handles PCEsc).
//
//   Ports
//     pc        in  ADDR_W  current program counter
//     imm5      in  5       immediate field of the executing instruction
//     jump      in  1       page jump requested by control
//     branch_ne in  1       bne in execution
//     zero      in  1       ALU result == 0
//     next_pc   out ADDR_W  selected next program counter
//
//   Selection priority: jump, then taken bne (branch_ne & ~zero), then pc+1.
//   All arithmetic is ADDR_W-bit modulo; wrap in either direction is silent.
// -----------------------------------------------------------------------------
module busca_instrucao_calc_prox_pc
  import busca_instrucao_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM5_W-1:0] imm5,
  input  logic              jump,
  input  logic              branch_ne,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc
);

  function automatic logic signed [ADDR_W-1:0] sext_imm5(input logic [IMM5_W-1:0] v);
    return signed'({{(ADDR_W-IMM5_W){v[IMM5_W-1]}}, v});
  endfunction

  logic        [ADDR_W-1:0] pc1;
  logic signed [ADDR_W-1:0] offset;
  logic        [ADDR_W-1:0] pc_jump;
  logic        [ADDR_W-1:0] pc_branch;

  assign pc1    = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign offset = sext_imm5(imm5);

  // Page jump keeps the page of pc+1, not of pc, so a jump sitting in the
  // last word of a page lands in the following page.
  assign pc_jump   = {pc1[ADDR_W-1:IMM5_W], imm5};
  assign pc_branch = pc1 + $unsigned(offset);

  always_comb begin
    next_pc = pc1;
    if (jump) begin
      next_pc = pc_jump;
    end else if (branch_ne && !zero) begin
      next_pc = pc_branch;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// -----------------------------------------------------------------------------
// busca_instrucao
//   nRISC instruction fetch / PC stage, directly upstream of the registered
//   control unit. Because control outputs arrive one cycle after it samples
//   the opcode, each instruction takes three phases: FETCH loads IR, DECODE
//   lets control sample the opcode, EXEC applies control's next-PC decision.
//
//   Ports
//     clock      in  1        single clock, all state on posedge
//     reset      in  1        synchronous, active-low
//     start      in  1        leave IDLE and begin fetching at PC=0
//     imem_addr  out ADDR_W   instruction memory address (= pc)
//     imem_data  in  INSTR_W  instruction memory read data (async read)
//     PCEsc      in  1        from control: 0 = halt
//     BranchNE   in  1        from control: bne in execution
//     Jump       in  1        from control: jump in execution
//     zero       in  1        ALU result == 0, meaningful in EXEC
//     pc         out ADDR_W   current PC
//     ir         out INSTR_W  instruction register
//     opcode     out 3        ir[INSTR_W-1 -: 3], to control
//     imm5       out 5        ir[4:0], to datapath
//     exec_en    out 1        high only in EXEC; gates regfile/memory writes
//     halted     out 1        high in HALT
// -----------------------------------------------------------------------------
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                PCEsc,
  input  logic                BranchNE,
  input  logic                Jump,
  input  logic                zero,
  output logic [ADDR_W-1:0]   pc,
  output logic [INSTR_W-1:0]  ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic [IMM5_W-1:0]   imm5,
  output logic                exec_en,
  output logic                halted
);

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [ADDR_W-1:0]   next_pc;

  busca_instrucao_calc_prox_pc #(
    .ADDR_W (ADDR_W)
  ) u_calc_prox_pc (
    .pc        (pc_q),
    .imm5      (ir_q[IMM5_W-1:0]),
    .jump      (Jump),
    .branch_ne (BranchNE),
    .zero      (zero),
    .next_pc   (next_pc)
  );

  // Sequencer, PC and IR. Reset clears everything, including an in-flight
  // instruction, so exec_en is guaranteed low right after a reset edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ir_q    <= imem_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!PCEsc) begin
            state_q <= ST_HALT;
          end else begin
            pc_q    <= next_pc;
            state_q <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[INSTR_W-1 -: OPCODE_W];
  assign imm5      = ir_q[IMM5_W-1:0];
  assign exec_en   = (state_q == ST_EXEC);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_busca_instrucao.sv
// -----------------------------------------------------------------------------
// tb_busca_instrucao
//   Directed bench for the nRISC fetch stage. The bench plays the part of the
//   instruction memory and of the control unit. Expected IR values and
//   expected retire PCs are queued when an instruction is issued; a monitor
//   pops and compares them as the DUT enters and leaves EXEC.
// -----------------------------------------------------------------------------
module tb_busca_instrucao;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               PCEsc, BranchNE, Jump, zero;
  logic [ADDR_W-1:0]  imem_addr, pc;
  logic [INSTR_W-1:0] imem_data, ir;
  logic [2:0]         opcode;
  logic [4:0]         imm5;
  logic               exec_en, halted;

  logic [INSTR_W-1:0] mem [0:255];
  assign imem_data = mem[imem_addr];

  always #5 clock = ~clock;

  busca_instrucao #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .PCEsc     (PCEsc),
    .BranchNE  (BranchNE),
    .Jump      (Jump),
    .zero      (zero),
    .pc        (pc),
    .ir        (ir),
    .opcode    (opcode),
    .imm5      (imm5),
    .exec_en   (exec_en),
    .halted    (halted)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              halted;
  } retire_t;

  logic [INSTR_W-1:0] ir_q [$];
  retire_t            rt_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Control inputs outside EXEC are driven to values that would change PC or
  // halt if the DUT wrongly looked at them.
  task automatic idle_ctrl();
    PCEsc    = 1'b0;
    Jump     = 1'b1;
    BranchNE = 1'b1;
    zero     = 1'b1;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    logic prev_exec;
    prev_exec = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (prev_exec && reset) begin
        if (rt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire_unexpected actual_pc=0x%0h required=no_retire", pc);
        end else begin
          retire_t e;
          e = rt_q.pop_front();
          check("retire_pc", {24'd0, pc}, {24'd0, e.pc});
          check("retire_halted", {31'd0, halted}, {31'd0, e.halted});
        end
      end
      if (exec_en && !prev_exec) begin
        if (ir_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL exec_unexpected actual_ir=0x%0h required=no_exec", ir);
        end else begin
          logic [INSTR_W-1:0] e_ir;
          e_ir = ir_q.pop_front();
          check("exec_ir", {24'd0, ir}, {24'd0, e_ir});
          check("exec_opcode", {29'd0, opcode}, {29'd0, e_ir[7:5]});
          check("exec_imm5", {27'd0, imm5}, {27'd0, e_ir[4:0]});
        end
      end
      prev_exec = exec_en;
    end
  end

  // Issue one instruction from the current position: queue expectations,
  // wait for EXEC, drive control for that single cycle.
  task automatic run_instr(input logic [7:0] e_ir, input logic pcesc, input logic j,
                           input logic b, input logic z, input logic [7:0] e_pc,
                           input logic e_h);
    int n;
    ir_q.push_back(e_ir);
    rt_q.push_back({e_pc, e_h});
    n = 0;
    while (!exec_en && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (!exec_en) begin
      checks++;
      failures++;
      $display("FAIL exec_timeout actual=no_exec required=exec_within_8_cycles ir=0x%0h", e_ir);
      finish_run();
    end
    PCEsc    = pcesc;
    Jump     = j;
    BranchNE = b;
    zero     = z;
    @(negedge clock);
    idle_ctrl();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h81;  // add   100_00001
    mem[8'h01] = 8'hD0;  // jump  110_10000 -> 0x10
    mem[8'h10] = 8'hC7;  // jump  110_00111 -> 0x07
    mem[8'h07] = 8'h0F;  // bne   +15       -> 0x17
    mem[8'h17] = 8'h08;  // bne   +8        -> 0x20
    mem[8'h20] = 8'h1E;  // bne   -2        -> 0x1F / 0x21
    mem[8'h1F] = 8'h00;  // bne   +0        -> 0x20
    mem[8'h21] = 8'h10;  // bne   -16       -> 0x12
    mem[8'h12] = 8'h10;  // bne   -16       -> 0x03
    mem[8'h03] = 8'h10;  // bne   -16       -> 0xF4 (wraps below 0)
    mem[8'hF4] = 8'hC5;  // jump  5         -> 0xE5
    mem[8'hE5] = 8'hC3;  // jump  3         -> 0xE3
    mem[8'hE3] = 8'hDF;  // jump  31        -> 0xFF
    mem[8'hFF] = 8'h05;  // bne   not taken -> 0x00 (wraps above max)

    idle_ctrl();
    start = 1'b0;
    reset = 1'b0;

    // Reset for two cycles, then released with no start.
    repeat (2) @(negedge clock);
    check("rst_pc", {24'd0, pc}, 32'h00);
    check("rst_ir", {24'd0, ir}, 32'h00);
    check("rst_halted", {31'd0, halted}, 32'h0);
    check("rst_exec_en", {31'd0, exec_en}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_pc", {24'd0, pc}, 32'h00);
    check("idle_ir", {24'd0, ir}, 32'h00);
    check("idle_exec_en", {31'd0, exec_en}, 32'h0);
    check("idle_imem_addr", {24'd0, imem_addr}, 32'h00);

    // First instruction: start pulse, phase timing.
    ir_q.push_back(8'h81);
    rt_q.push_back({8'h01, 1'b0});
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("fetch_exec_en", {31'd0, exec_en}, 32'h0);
    @(negedge clock);
    check("decode_ir", {24'd0, ir}, 32'h81);
    check("decode_exec_en", {31'd0, exec_en}, 32'h0);
    @(negedge clock);
    check("exec_en_third_cycle", {31'd0, exec_en}, 32'h1);
    PCEsc = 1'b1; Jump = 1'b0; BranchNE = 1'b0; zero = 1'b0;
    @(negedge clock);
    idle_ctrl();
    mem[8'h00] = 8'hE0;  // halt 111_00000 for the second visit to address 0

    // start held high while running: must be ignored outside IDLE.
    start = 1'b1;
    run_instr(8'hD0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
    run_instr(8'hC7, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0);  // Jump beats BranchNE
    run_instr(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 8'h17, 1'b0);
    run_instr(8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0);
    run_instr(8'h1E, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0);  // bne -2 taken
    run_instr(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0);
    run_instr(8'h1E, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b0);  // bne not taken
    run_instr(8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0);
    run_instr(8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0);
    run_instr(8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'hF4, 1'b0);
    run_instr(8'hC5, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE5, 1'b0);
    run_instr(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE3, 1'b0);
    run_instr(8'hDF, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    run_instr(8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    // Halt with Jump and BranchNE also high: PCEsc==0 wins, pc held.
    run_instr(8'hE0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    start = 1'b0;

    // HALT is sticky: pc/ir frozen through start pulses and memory changes.
    mem[8'h00] = 8'h55;
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      @(negedge clock);
      check("halt_pc", {24'd0, pc}, 32'h00);
      check("halt_ir", {24'd0, ir}, 32'hE0);
      check("halt_halted", {31'd0, halted}, 32'h1);
      check("halt_exec_en", {31'd0, exec_en}, 32'h0);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("halt_rst_pc", {24'd0, pc}, 32'h00);
    check("halt_rst_ir", {24'd0, ir}, 32'h00);
    check("halt_rst_halted", {31'd0, halted}, 32'h0);
    reset = 1'b1;
    mem[8'h00] = 8'h81;
    @(negedge clock);
    check("post_halt_idle_exec_en", {31'd0, exec_en}, 32'h0);

    // Reset during DECODE aborts the instruction before EXEC.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre_abort_decode_ir", {24'd0, ir}, 32'h81);
    reset = 1'b0;
    @(negedge clock);
    check("abort_decode_exec_en", {31'd0, exec_en}, 32'h0);
    check("abort_decode_pc", {24'd0, pc}, 32'h00);
    check("abort_decode_ir", {24'd0, ir}, 32'h00);
    reset = 1'b1;
    @(negedge clock);
    check("abort_decode_idle", {31'd0, exec_en}, 32'h0);

    // Reset during EXEC with a jump pending: pc must not move.
    ir_q.push_back(8'h81);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre_abort_exec_en", {31'd0, exec_en}, 32'h1);
    PCEsc = 1'b1; Jump = 1'b1; BranchNE = 1'b0; zero = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("abort_exec_exec_en", {31'd0, exec_en}, 32'h0);
    check("abort_exec_pc", {24'd0, pc}, 32'h00);
    check("abort_exec_ir", {24'd0, ir}, 32'h00);
    check("abort_exec_halted", {31'd0, halted}, 32'h0);
    idle_ctrl();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("abort_exec_idle_exec_en", {31'd0, exec_en}, 32'h0);
    check("abort_exec_idle_pc", {24'd0, pc}, 32'h00);

    check("ir_queue_drained", ir_q.size(), 32'd0);
    check("retire_queue_drained", rt_q.size(), 32'd0);
    finish_run();
  end

endmodule
